decoder38_strobe: RTL and testbench

//  Sequenced 3-8 decoder: the receiving end of the 8-3 priority encoder channel-code path.

---
 rtl/decoder38_strobe.sv | 161 ++++++++++++++++
 tb/tb_decoder38_strobe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/decoder38_strobe.sv
// decoder38_strobe: sequenced 3-to-8 decoder with an active-low strobe bus.
// A 3-bit channel code is accepted over a valid/ready handshake. The selected
// line of the 8-line bus is driven low for PULSE_LEN cycles. All lines are then
// held high for a GAP_LEN-cycle guard gap.
// Optional feature macro: DEC38_QUEUE_EN inserts a QDEPTH-entry command FIFO
// between the handshake and the sequencer.
module decoder38_strobe #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int QDEPTH    = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iEI,
  input  logic       iValid,
  input  logic [2:0] iCode,
  output logic       oReady,
  output logic [7:0] oData,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_LOAD   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

  // Reject illegal parameter combinations at elaboration time.
  if ((PULSE_LEN < 1) || (PULSE_LEN > 255) || (GAP_LEN < 0) || (GAP_LEN > 255) ||
      (QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_param_check
    $error("decoder38_strobe: illegal parameter value");
  end

  // Active-low one-hot pattern for a channel code.
  function automatic logic [7:0] strobe_pattern(input logic [2:0] code);
    strobe_pattern = ~(8'b0000_0001 << code);
  endfunction

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [7:0] data_r;
  logic       busy_r;
  logic       done_r;

  logic       start_s;
  logic [2:0] start_code_s;

`ifdef DEC38_QUEUE_EN
  localparam int PW = $clog2(QDEPTH);

  logic [2:0]  mem_r [QDEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   qcnt_r;
  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;

  assign full_s       = (qcnt_r == (PW+1)'(QDEPTH));
  assign empty_s      = (qcnt_r == {(PW+1){1'b0}});
  assign oReady       = ~full_s & ~iEI;
  assign push_s       = iValid & oReady;
  assign pop_s        = (state_r == ST_IDLE) & ~empty_s & ~iEI;
  assign start_s      = pop_s;
  assign start_code_s = mem_r[rd_ptr_r];
  assign oBusy        = busy_r | ~empty_s;

  // Command FIFO: flushed by reset or disable, otherwise push/pop bookkeeping.
  always_ff @(posedge iClk) begin
    if (!iRst_n || iEI) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      qcnt_r   <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= iCode;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   qcnt_r <= qcnt_r + (PW+1)'(1);
        2'b01:   qcnt_r <= qcnt_r - (PW+1)'(1);
        default: qcnt_r <= qcnt_r;
      endcase
    end
  end
`else
  assign oReady       = (state_r == ST_IDLE) & ~iEI;
  assign start_s      = iValid & oReady;
  assign start_code_s = iCode;
  assign oBusy        = busy_r;
`endif

  // Strobe sequencer: IDLE -> PULSE -> (GAP) -> IDLE with registered bus outputs.
  always_ff @(posedge iClk) begin
    if (!iRst_n || iEI) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      data_r  <= 8'hFF;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_s) begin
            state_r <= ST_PULSE;
            cnt_r   <= PULSE_LOAD;
            data_r  <= strobe_pattern(start_code_s);
            busy_r  <= 1'b1;
          end else begin
            cnt_r   <= 8'd0;
            data_r  <= 8'hFF;
            busy_r  <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else if (GAP_LEN == 0) begin
            state_r <= ST_IDLE;
            data_r  <= 8'hFF;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_GAP;
            cnt_r   <= GAP_LOAD;
            data_r  <= 8'hFF;
          end
        end
        ST_GAP: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 8'd0;
          data_r  <= 8'hFF;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oData = data_r;
  assign oDone = done_r;

endmodule

// File: tb/tb_decoder38_strobe.sv
// Self-checking bench for decoder38_strobe: directed scenarios plus randomized
// traffic against a timeline reference model (cycles since accept).
module tb_decoder38_strobe;

  localparam int TP = 4;
  localparam int TG = 2;

  logic       clk;
  logic       rst_n, ei, valid;
  logic [2:0] code;
  logic       ready, busy, done;
  logic [7:0] data;

  logic       valid1;
  logic [2:0] code1;
  logic       ready1, busy1, done1;
  logic [7:0] data1;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit         m_known = 0;
  bit         m_active = 0;
  int         m_off = 0;
  int         m_code = 0;
  logic [7:0] exp_data;
  logic       exp_busy, exp_done;

  decoder38_strobe #(.PULSE_LEN(TP), .GAP_LEN(TG), .QDEPTH(4)) dut (
    .iClk(clk), .iRst_n(rst_n), .iEI(ei), .iValid(valid), .iCode(code),
    .oReady(ready), .oData(data), .oBusy(busy), .oDone(done));

  decoder38_strobe #(.PULSE_LEN(1), .GAP_LEN(0), .QDEPTH(4)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iEI(ei), .iValid(valid1), .iCode(code1),
    .oReady(ready1), .oData(data1), .oBusy(busy1), .oDone(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready, clock, advance model, check outputs.
  task automatic step(input bit r, input bit e, input bit v, input logic [2:0] c,
                      output bit acc);
    rst_n = r; ei = e; valid = v; code = c;
    #1;
    if (m_known) check("ready", {7'd0, ready}, {7'd0, (!m_active && !e)});
    acc = r && !e && v && !m_active;
    @(posedge clk); #1;
    if (!r || e) begin
      m_active = 0;
      exp_data = 8'hFF; exp_busy = 1'b0; exp_done = 1'b0;
      if (!r) m_known = 1;
    end else begin
      exp_done = 1'b0;
      if (m_active) m_off++;
      if (acc) begin m_active = 1; m_off = 1; m_code = c; end
      if (m_active) begin
        if (m_off <= TP) begin
          exp_data = 8'(255 - (1 << m_code)); exp_busy = 1'b1;
        end else if (m_off <= TP + TG) begin
          exp_data = 8'hFF; exp_busy = 1'b1;
        end else begin
          exp_data = 8'hFF; exp_busy = 1'b0; exp_done = 1'b1; m_active = 0;
        end
      end else begin
        exp_data = 8'hFF; exp_busy = 1'b0;
      end
    end
    check("data", data, exp_data);
    check("busy", {7'd0, busy}, {7'd0, exp_busy});
    check("done", {7'd0, done}, {7'd0, exp_done});
  endtask

  initial begin
    bit acc;
    valid1 = 1'b0; code1 = 3'd0;
    rst_n = 1'b0; ei = 1'b0; valid = 1'b0; code = 3'd0;

    // reset held for two cycles, then idle
    step(1'b0, 1'b0, 1'b0, 3'd0, acc);
    step(1'b0, 1'b0, 1'b0, 3'd0, acc);
    check("reset_ready", {7'd0, ready}, 8'd1);
    step(1'b1, 1'b0, 1'b0, 3'd0, acc);

`ifdef DEC38_QUEUE_EN
    begin
      int next;
      bit pre;
      bit saw_stall;
      logic [7:0] prev;
      logic [7:0] seen[$];
      next = 0; saw_stall = 0; prev = 8'hFF;
      for (int cyc = 0; cyc < 300 && seen.size() < 6; cyc++) begin
        valid = (next < 6);
        code  = 3'(next);
        #1;
        pre = valid && ready;
        if (valid && !ready) saw_stall = 1;
        @(posedge clk); #1;
        if (pre) next++;
        if (data != 8'hFF && prev == 8'hFF) seen.push_back(data);
        prev = data;
      end
      check("q_stall", {7'd0, saw_stall}, 8'd1);
      check("q_count", 8'(seen.size()), 8'd6);
      for (int i = 0; i < seen.size(); i++)
        check("q_order", seen[i], 8'(255 - (1 << i)));
      // queue several codes, then reset mid-run
      for (int i = 0; i < 3; i++) begin
        valid = 1'b1; code = 3'(i + 1);
        @(posedge clk); #1;
      end
      valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("q_rst_data", data, 8'hFF);
      check("q_rst_busy", {7'd0, busy}, 8'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        check("q_post_data", data, 8'hFF);
        check("q_post_busy", {7'd0, busy}, 8'd0);
      end
    end
`else
    // single code 5 with default timing
    step(1'b1, 1'b0, 1'b1, 3'd5, acc);
    check("c5_accept", {7'd0, acc}, 8'd1);
    check("c5_first", data, 8'hDF);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 3'd0, acc);

    // sweep 0..7 with valid held
    for (int i = 0; i < 8; i++) begin
      acc = 0;
      for (int k = 0; k < 10 && !acc; k++) step(1'b1, 1'b0, 1'b1, 3'(i), acc);
      check("sweep_accept", {7'd0, acc}, 8'd1);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 3'd0, acc);

    // abort during the second pulse cycle
    step(1'b1, 1'b0, 1'b1, 3'd3, acc);
    step(1'b1, 1'b0, 1'b0, 3'd0, acc);
    step(1'b1, 1'b1, 1'b0, 3'd0, acc);
    check("abort_data", data, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 3'd2, acc);
    check("abort_noacc", {7'd0, acc}, 8'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 3'd0, acc);

    // PULSE_LEN=1, GAP_LEN=0 instance, code 7
    valid1 = 1'b1; code1 = 3'd7;
    #1;
    check("p1_ready", {7'd0, ready1}, 8'd1);
    @(posedge clk); #1;
    valid1 = 1'b0;
    check("p1_data", data1, 8'h7F);
    check("p1_busy", {7'd0, busy1}, 8'd1);
    check("p1_done0", {7'd0, done1}, 8'd0);
    @(posedge clk); #1;
    check("p1_idle", data1, 8'hFF);
    check("p1_done", {7'd0, done1}, 8'd1);
    @(posedge clk); #1;
    check("p1_done_clr", {7'd0, done1}, 8'd0);
    // model stepped nothing during these cycles; dut stayed idle (valid=0)
    step(1'b1, 1'b0, 1'b0, 3'd0, acc);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 99) < 70), 3'($urandom_range(0, 7)), acc);
    end
    step(1'b0, 1'b0, 1'b0, 3'd0, acc);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
